// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps a single request outstanding to
// instruction memory and feeds the decode latch through an output register and a one-entry skid.
module pipeline_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        jmpctrl_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        slot_free_s;
    logic [31:0] pc_inc_s;
    logic [31:0] redirect_aligned_s;

    assign slot_free_s        = !valid_q || fetch_en;
    assign pc_inc_s           = pc_q + 32'd4;
    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

    // Next-state, request and output-register logic; a redirect overrides every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pcout_d      = pcout_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redirect_valid) begin
            pc_d         = redirect_aligned_s;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = 32'h0000_0000;
            // An outstanding request must still drain before a new one may launch.
            if ((state_q == S_WAIT || state_q == S_FLUSH) && !imem_rvalid) begin
                state_d = S_FLUSH;
                req_d   = 1'b1;
            end else begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        end else begin
            if (fetch_en) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end else begin
                valid_d = valid_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (!jmpctrl_en && slot_free_s) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_inc_s;
                        if (slot_free_s) begin
                            valid_d = 1'b1;
                            instr_d = imem_rdata;
                            pcout_d = addr_q;
                            if (!jmpctrl_en) begin
                                state_d = S_WAIT;
                                addr_d  = pc_inc_s;
                            end else begin
                                state_d = S_IDLE;
                                req_d   = 1'b0;
                            end
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = addr_q;
                            state_d      = S_FULL;
                            req_d        = 1'b0;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_FULL: begin
                    if (fetch_en) begin
                        valid_d = 1'b1;
                        instr_d = skid_instr_q;
                        pcout_d = skid_pc_q;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                S_FLUSH: begin
                    if (imem_rvalid) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pcout_q      <= 32'h0000_0000;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pcout_q      <= pcout_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pcout_q;

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: directed vector table, hand-written reset sequence,
// and random traffic checked against an in-order program-stream scoreboard.
module tb_pipeline_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        jmpctrl_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    pipeline_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .jmpctrl_en    (jmpctrl_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic        jc;
        logic        rv;
        logic        rd;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[32];
    int   errors = 0;
    int   checks = 0;

    // Behavioural instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_A5A5) + 32'h0101_0000;
    endfunction

    function automatic vec_t mk(input logic fe, input logic jc, input logic rv, input logic rd,
                                input logic [31:0] rpc, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.fe = fe; v.jc = jc; v.rv = rv; v.rd = rd; v.rpc = rpc;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        fetch_en       = 1'b0;
        jmpctrl_en     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0000_0000;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random-phase scoreboard state.
    logic [31:0] exp_pc;
    logic [31:0] req_addr;
    logic        busy;
    logic        block_launch;
    int          lat;
    int          consumed;

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 32'h0, 1, 32'h0000_0000, 0, 32'h0);
        vecs[1]  = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0004, 1, 32'h0000_0000);
        vecs[2]  = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0008, 1, 32'h0000_0004);
        vecs[3]  = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_000C, 1, 32'h0000_0008);
        vecs[4]  = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0010, 1, 32'h0000_000C);
        vecs[5]  = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0014, 1, 32'h0000_0010);
        vecs[6]  = mk(0, 0, 1, 0, 32'h0, 0, 32'h0000_0014, 1, 32'h0000_0010);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0, 0, 32'h0000_0014, 1, 32'h0000_0010);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0, 0, 32'h0000_0014, 1, 32'h0000_0010);
        vecs[9]  = mk(1, 0, 0, 0, 32'h0, 0, 32'h0000_0014, 1, 32'h0000_0014);
        vecs[10] = mk(1, 0, 0, 0, 32'h0, 1, 32'h0000_0018, 0, 32'h0);
        vecs[11] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_001C, 1, 32'h0000_0018);
        vecs[12] = mk(1, 1, 0, 0, 32'h0, 1, 32'h0000_001C, 0, 32'h0);
        vecs[13] = mk(1, 1, 1, 0, 32'h0, 0, 32'h0000_001C, 1, 32'h0000_001C);
        vecs[14] = mk(1, 1, 0, 0, 32'h0, 0, 32'h0000_001C, 0, 32'h0);
        vecs[15] = mk(1, 1, 0, 0, 32'h0, 0, 32'h0000_001C, 0, 32'h0);
        vecs[16] = mk(1, 0, 0, 1, 32'h0000_0200, 0, 32'h0000_001C, 0, 32'h0);
        vecs[17] = mk(1, 0, 0, 0, 32'h0, 1, 32'h0000_0200, 0, 32'h0);
        vecs[18] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0204, 1, 32'h0000_0200);
        vecs[19] = mk(1, 0, 0, 1, 32'h0000_0080, 1, 32'h0000_0204, 0, 32'h0);
        vecs[20] = mk(1, 0, 0, 0, 32'h0, 1, 32'h0000_0204, 0, 32'h0);
        vecs[21] = mk(1, 0, 1, 0, 32'h0, 0, 32'h0000_0204, 0, 32'h0);
        vecs[22] = mk(1, 0, 0, 0, 32'h0, 1, 32'h0000_0080, 0, 32'h0);
        vecs[23] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0084, 1, 32'h0000_0080);
        vecs[24] = mk(1, 0, 1, 1, 32'hFFFF_FFFE, 0, 32'h0000_0084, 0, 32'h0);
        vecs[25] = mk(1, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[26] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        vecs[27] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0000_0004, 1, 32'h0000_0000);
        vecs[28] = mk(0, 0, 0, 1, 32'h0000_0040, 1, 32'h0000_0004, 0, 32'h0);
        vecs[29] = mk(0, 0, 1, 0, 32'h0, 0, 32'h0000_0004, 0, 32'h0);
        vecs[30] = mk(0, 0, 0, 0, 32'h0, 1, 32'h0000_0040, 0, 32'h0);
        vecs[31] = mk(0, 0, 1, 0, 32'h0, 1, 32'h0000_0044, 1, 32'h0000_0040);

        // Reset state.
        do_reset();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, NOP_INSTR);
        chk("rst_pc_out", pc_out, 32'h0000_0000);

        // Directed vector table, inputs applied on the falling edge.
        for (int i = 0; i < 32; i++) begin
            fetch_en       = vecs[i].fe;
            jmpctrl_en     = vecs[i].jc;
            imem_rvalid    = vecs[i].rv;
            redirect_valid = vecs[i].rd;
            redirect_pc    = vecs[i].rpc;
            imem_rdata     = vecs[i].rv ? mem_word(imem_addr) : 32'hDEAD_BEEF;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_instr", i), instr_out,
                vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP_INSTR);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].exp_pc);
            end
        end

        // Asynchronous reset while a request is outstanding.
        do_reset();
        fetch_en = 1'b1;
        @(posedge clk); @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        @(posedge clk); @(negedge clk);
        imem_rvalid = 1'b0;
        chk("arst_pre_req", {31'd0, imem_req}, 32'd1);
        chk("arst_pre_valid", {31'd0, instr_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr_out, NOP_INSTR);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        chk("arst_no_capture", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b0;
        rst_n = 1'b1;
        chk("arst_rel_addr", imem_addr, RESET_PC);
        @(posedge clk); @(negedge clk);
        chk("arst_first_req", {31'd0, imem_req}, 32'd1);
        chk("arst_first_addr", imem_addr, RESET_PC);

        // Random traffic: decoded stream must be the program order since the last redirect.
        do_reset();
        exp_pc   = RESET_PC;
        busy     = 1'b0;
        lat      = 0;
        req_addr = 32'h0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            jmpctrl_en     = ($urandom_range(0, 9) < 2);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
            end
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    lat      = $urandom_range(0, 3);
                    req_addr = imem_addr;
                end else begin
                    chk("addr_stable", imem_addr, req_addr);
                end
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(req_addr);
                    busy        = 1'b0;
                end else begin
                    lat--;
                end
            end else if (busy) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                busy = 1'b0;
            end
            if (!instr_valid) begin
                chk("nop_when_invalid", instr_out, NOP_INSTR);
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (instr_valid && fetch_en) begin
                chk("stream_pc", pc_out, exp_pc);
                chk("stream_instr", instr_out, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            block_launch = !imem_req && jmpctrl_en;
            @(posedge clk); @(negedge clk);
            if (block_launch) begin
                chk("jmpctrl_no_launch", {31'd0, imem_req}, 32'd0);
            end
        end
        chk("progress", {31'd0, (consumed >= 200)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
